// File: rtl/iop_dispatcher.sv
// I/O request sequencer for one IOP: decodes a CPU I/O instruction, grants a single
// device controller, waits for completion or timeout and returns a condition code.
module iop_dispatcher #(
    parameter int                 IOP_ID      = 0,
    parameter int                 NUM_DEV     = 8,
    parameter logic [0:NUM_DEV-1] DEV_PRESENT = 8'h44,
    parameter int                 TIMEOUT     = 256
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               cpu_req,
    input  logic [0:2]         iop_func,
    input  logic [21:31]       iop_device,
    output logic               cpu_ack,
    output logic [0:1]         iop_cc,
    output logic               busy,
    output logic [0:NUM_DEV-1] dev_active,
    output logic [0:2]         dev_func,
    input  logic [0:NUM_DEV-1] dev_done,
    input  logic [0:1]         dev_cc
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_DECODE,
        S_RUN,
        S_DONE,
        S_RELEASE
    } state_t;

    state_t state, state_nx;

    logic [7:0]         dev_sel, dev_sel_nx;
    logic [2:0]         iop_num, iop_num_nx;
    logic [15:0]        count, count_nx;
    logic [0:NUM_DEV-1] active_nx;
    logic [0:NUM_DEV-1] grant_mask;
    logic [0:1]         cc_nx;
    logic [0:2]         func_nx;
    logic               ack_nx;
    logic               busy_nx;
    logic               func_ok;
    logic               reject;
    logic               done_hit;
    logic               timeout_hit;

    // A device number beyond NUM_DEV yields an all-zero mask, so it fails the presence test too.
    always_comb begin
        grant_mask = '0;
        for (int i = 0; i < NUM_DEV; i++) begin
            grant_mask[i] = (dev_sel == 8'(i));
        end
    end

    assign func_ok     = (dev_func <= 3'd3) || (dev_func == 3'd6);
    assign reject      = (iop_num != 3'(IOP_ID)) || ((grant_mask & DEV_PRESENT) == '0) || !func_ok;
    assign done_hit    = |(dev_done & dev_active);
    assign timeout_hit = (count == 16'(TIMEOUT - 1));

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:    if (cpu_req) state_nx = S_DECODE;
            S_DECODE:  state_nx = reject ? S_DONE : S_RUN;
            S_RUN:     if (done_hit || timeout_hit) state_nx = S_DONE;
            S_DONE:    state_nx = S_RELEASE;
            S_RELEASE: if (!cpu_req) state_nx = S_IDLE;
            default:   state_nx = S_IDLE;
        endcase
    end

    always_comb begin
        active_nx  = dev_active;
        ack_nx     = cpu_ack;
        cc_nx      = iop_cc;
        func_nx    = dev_func;
        dev_sel_nx = dev_sel;
        iop_num_nx = iop_num;
        count_nx   = count;
        busy_nx    = (state_nx != S_IDLE);
        case (state)
            S_IDLE: begin
                if (cpu_req) begin
                    func_nx    = iop_func;
                    dev_sel_nx = iop_device[24:31];
                    iop_num_nx = iop_device[21:23];
                end
            end
            S_DECODE: begin
                if (reject) begin
                    cc_nx = 2'b11;
                end else begin
                    active_nx = grant_mask;
                    count_nx  = '0;
                end
            end
            S_RUN: begin
                // Completion takes priority over a timeout landing on the same edge.
                if (done_hit) begin
                    active_nx = '0;
                    cc_nx     = dev_cc;
                end else if (timeout_hit) begin
                    active_nx = '0;
                    cc_nx     = 2'b10;
                end else begin
                    count_nx = count + 16'd1;
                end
            end
            S_DONE:    ack_nx = 1'b1;
            S_RELEASE: if (!cpu_req) ack_nx = 1'b0;
            default:   ack_nx = 1'b0;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            dev_active <= '0;
            cpu_ack    <= 1'b0;
            iop_cc     <= 2'b00;
            dev_func   <= 3'd0;
            busy       <= 1'b0;
            dev_sel    <= 8'd0;
            iop_num    <= 3'd0;
            count      <= 16'd0;
        end else begin
            dev_active <= active_nx;
            cpu_ack    <= ack_nx;
            iop_cc     <= cc_nx;
            dev_func   <= func_nx;
            busy       <= busy_nx;
            dev_sel    <= dev_sel_nx;
            iop_num    <= iop_num_nx;
            count      <= count_nx;
        end
    end

endmodule

// File: tb/tb_iop_dispatcher.sv
// Directed bench for iop_dispatcher: table of request records plus reset and
// handshake sequences, with a small device model driving dev_done.
module tb_iop_dispatcher;

    logic         clock = 1'b0;
    logic         reset;
    logic         cpu_req;
    logic [0:2]   iop_func;
    logic [21:31] iop_device;
    logic         cpu_ack;
    logic [0:1]   iop_cc;
    logic         busy;
    logic [0:7]   dev_active;
    logic [0:2]   dev_func;
    logic [0:7]   dev_done;
    logic [0:1]   dev_cc;

    int checks   = 0;
    int failures = 0;
    int overlap  = 0;

    iop_dispatcher #(
        .IOP_ID     (0),
        .NUM_DEV    (8),
        .DEV_PRESENT(8'h44),
        .TIMEOUT    (16)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .cpu_req   (cpu_req),
        .iop_func  (iop_func),
        .iop_device(iop_device),
        .cpu_ack   (cpu_ack),
        .iop_cc    (iop_cc),
        .busy      (busy),
        .dev_active(dev_active),
        .dev_func  (dev_func),
        .dev_done  (dev_done),
        .dev_cc    (dev_cc)
    );

    always #5 clock = ~clock;

    always @(negedge clock) begin
        if ($countones(dev_active) > 1) overlap++;
    end

    typedef struct {
        logic [2:0]  func;
        logic [10:0] dev;
        int          done_at;   // active cycles before the model signals done; 0 = never
        logic [1:0]  cc;
        bit          stray;     // pulse dev_done[1] on the second active cycle
        logic [7:0]  exp_mask;
        int          exp_act;
        logic [1:0]  exp_cc;
        int          exp_ack;   // edges from request sample to cpu_ack visible, plus one
    } vec_t;

    vec_t vecs[13];

    task automatic check(input string name, input int actual, input int expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, actual, expected);
        end
    endtask

    // Called at a negedge; returns at the negedge where cpu_ack has been seen low again.
    task automatic run_txn(input vec_t v, input int idx);
        int         n;
        int         act;
        int         ack_lat;
        logic [7:0] seen;
        logic [1:0] cc_seen;
        logic [2:0] fseen;
        logic       busy1;
        n = 0; act = 0; ack_lat = -1; seen = '0; cc_seen = '0; fseen = '0; busy1 = 1'b0;
        cpu_req    = 1'b1;
        iop_func   = v.func;
        iop_device = v.dev;
        dev_done   = '0;
        dev_cc     = v.cc;
        while (ack_lat < 0 && n < 60) begin
            @(negedge clock);
            n++;
            if (n == 1) busy1 = busy;
            if (dev_active != '0) begin
                act++;
                seen  = seen | dev_active;
                fseen = dev_func;
            end
            if (cpu_ack) begin
                ack_lat = n;
                cc_seen = iop_cc;
            end
            dev_done = (dev_active != '0 && act == v.done_at) ? v.exp_mask : 8'h00;
            if (v.stray && act == 2 && dev_active != '0) dev_done = dev_done | 8'b0100_0000;
        end
        dev_done = '0;
        check($sformatf("v%0d busy", idx), busy1, 1);
        check($sformatf("v%0d active_cycles", idx), act, v.exp_act);
        check($sformatf("v%0d active_mask", idx), seen, v.exp_mask);
        check($sformatf("v%0d ack_latency", idx), ack_lat, v.exp_ack);
        check($sformatf("v%0d iop_cc", idx), cc_seen, v.exp_cc);
        if (v.exp_act > 0) check($sformatf("v%0d dev_func", idx), fseen, v.func);
        cpu_req = 1'b0;
        @(negedge clock);
        check($sformatf("v%0d ack_drop", idx), cpu_ack, 0);
        check($sformatf("v%0d idle_busy", idx), busy, 0);
    endtask

    initial begin
        //           func  dev      done cc    stray mask          act cc     ack
        vecs[0]  = '{3'd1, 11'h005, 2,   2'b01, 1'b0, 8'b0000_0100, 2,  2'b01, 5};
        vecs[1]  = '{3'd0, 11'h001, 3,   2'b00, 1'b0, 8'b0100_0000, 3,  2'b00, 6};
        vecs[2]  = '{3'd0, 11'h003, 0,   2'b00, 1'b0, 8'b0000_0000, 0,  2'b11, 3};
        vecs[3]  = '{3'd0, 11'h101, 0,   2'b00, 1'b0, 8'b0000_0000, 0,  2'b11, 3};
        vecs[4]  = '{3'd5, 11'h001, 0,   2'b00, 1'b0, 8'b0000_0000, 0,  2'b11, 3};
        vecs[5]  = '{3'd7, 11'h005, 0,   2'b00, 1'b0, 8'b0000_0000, 0,  2'b11, 3};
        vecs[6]  = '{3'd0, 11'h0FF, 0,   2'b00, 1'b0, 8'b0000_0000, 0,  2'b11, 3};
        vecs[7]  = '{3'd3, 11'h005, 1,   2'b10, 1'b0, 8'b0000_0100, 1,  2'b10, 4};
        vecs[8]  = '{3'd6, 11'h001, 5,   2'b11, 1'b0, 8'b0100_0000, 5,  2'b11, 8};
        vecs[9]  = '{3'd2, 11'h005, 1,   2'b00, 1'b0, 8'b0000_0100, 1,  2'b00, 4};
        vecs[10] = '{3'd0, 11'h005, 0,   2'b11, 1'b0, 8'b0000_0100, 16, 2'b10, 19};
        vecs[11] = '{3'd0, 11'h005, 16,  2'b01, 1'b0, 8'b0000_0100, 16, 2'b01, 19};
        vecs[12] = '{3'd1, 11'h005, 4,   2'b01, 1'b1, 8'b0000_0100, 4,  2'b01, 7};

        reset = 1'b0; cpu_req = 1'b0; iop_func = '0; iop_device = '0; dev_done = '0; dev_cc = '0;
        #1 reset = 1'b1;
        repeat (2) @(negedge clock);
        check("reset active", dev_active, 0);
        check("reset ack", cpu_ack, 0);
        check("reset busy", busy, 0);
        check("reset cc", iop_cc, 0);
        check("reset func", dev_func, 0);
        reset = 1'b0;
        @(negedge clock);

        for (int i = 0; i < 13; i++) run_txn(vecs[i], i);

        // Asynchronous reset in the middle of a grant to device 5.
        cpu_req = 1'b1; iop_func = 3'd1; iop_device = 11'h005;
        repeat (4) @(negedge clock);
        check("mid_run active", dev_active, 8'b0000_0100);
        check("mid_run cc_before", iop_cc, 1);
        #2 reset = 1'b1;
        #1;
        check("async_rst active", dev_active, 0);
        check("async_rst ack", cpu_ack, 0);
        check("async_rst busy", busy, 0);
        check("async_rst cc", iop_cc, 0);
        check("async_rst func", dev_func, 0);
        cpu_req = 1'b0;
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        run_txn(vecs[1], 99);

        check("no_overlap", overlap, 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
